// File: rtl/wb_cpu_bridge_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge.
package wb_cpu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL_READ         = 4'hF;

endpackage

// File: rtl/wb_cpu_bridge_if.sv
// CPU native memory port and Wishbone classic bus bundled together;
// master is the bridge side, slave is the CPU plus bus slave side.
interface wb_cpu_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    logic [ADDR_WIDTH-1:0] adr_o;
    logic [31:0]           dat_o;
    logic [31:0]           dat_i;
    logic [3:0]            sel_o;
    logic                  we_o;
    logic                  cyc_o;
    logic                  stb_o;
    logic                  ack_i;
    logic                  err_i;

    modport master (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
        output dat_i, ack_i, err_i
    );

endinterface

// File: rtl/wb_cpu_bridge_watchdog.sv
// Saturating cycle counter with clear, enable and terminal-count flag.
module wb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/wb_cpu_bridge.sv
// Wishbone classic master for the CPU memory port, with bus watchdog.
module wb_cpu_bridge
    import wb_cpu_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_cpu_bridge_if.master        bus,
    output logic                   bus_err,
    input  logic                   err_clr
);
    state_t state, state_n;
    logic   start, fin, abort, tc, err_set;

    wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .en  (state == BUS),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A response on the terminal-count cycle beats the watchdog.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        fin     = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: if (bus.mem_valid) begin
                start   = 1'b1;
                state_n = BUS;
            end
            BUS: if (bus.ack_i || bus.err_i) begin
                fin     = 1'b1;
                state_n = DONE;
            end else if (tc) begin
                abort   = 1'b1;
                state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign err_set       = (fin && bus.err_i) || abort;
    assign bus.mem_ready = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.adr_o     <= {ADDR_WIDTH{1'b0}};
            bus.dat_o     <= '0;
            bus.sel_o     <= '0;
            bus.we_o      <= 1'b0;
            bus.cyc_o     <= 1'b0;
            bus.stb_o     <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            if (start) begin
                bus.adr_o <= bus.mem_addr;
                bus.dat_o <= bus.mem_wdata;
                bus.we_o  <= |bus.mem_wstrb;
                bus.sel_o <= (|bus.mem_wstrb) ? bus.mem_wstrb : SEL_READ;
                bus.cyc_o <= 1'b1;
                bus.stb_o <= 1'b1;
            end
            if (fin || abort) begin
                bus.cyc_o <= 1'b0;
                bus.stb_o <= 1'b0;
                if (bus.we_o)       bus.mem_rdata <= '0;
                else if (err_set)   bus.mem_rdata <= TIMEOUT_DATA;
                else                bus.mem_rdata <= bus.dat_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          bus_err <= 1'b0;
        else if (err_set) bus_err <= 1'b1;
        else if (err_clr) bus_err <= 1'b0;
    end

endmodule

// File: tb/tb_wb_cpu_bridge.sv
// Directed plus randomized bench for wb_cpu_bridge with a transaction-level model.
module tb_wb_cpu_bridge;
    localparam int          AW = 32;
    localparam int          T  = 8;
    localparam logic [31:0] TD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic bus_err;
    int   checks = 0;
    int   failures = 0;
    logic exp_err = 1'b0;

    wb_cpu_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    wb_cpu_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_DATA   (TD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .bus_err (bus_err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU request; ack_at = cycle of cyc_o on which the slave answers
    // (0 or beyond T means the slave never answers).
    task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] rd,
                       input int ack_at, input bit use_err,
                       input bit clr_same);
        bit          acked, set_err, seen, prev_ack;
        int          exp_cyc, cyc_cnt, n, rdy_n;
        logic [31:0] exp_rd;
        acked    = (ack_at >= 1) && (ack_at <= T);
        exp_cyc  = acked ? ack_at : T;
        set_err  = !acked || use_err;
        exp_rd   = (ws != 4'h0) ? 32'h0 : (set_err ? TD : rd);
        seen     = 1'b0;
        prev_ack = 1'b0;
        cyc_cnt  = 0;
        n        = 0;
        rdy_n    = -1;

        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        bus.dat_i     = rd;
        bus.ack_i     = 1'b0;
        bus.err_i     = 1'b0;
        for (int i = 0; i < T + 8 && !seen; i++) begin
            @(negedge clk);
            n++;
            bus.ack_i = 1'b0;
            bus.err_i = 1'b0;
            err_clr   = 1'b0;
            if (prev_ack) check("stb_after_ack", bus.stb_o, 1'b0);
            prev_ack = 1'b0;
            if (bus.cyc_o) begin
                cyc_cnt++;
                check("stb_with_cyc", bus.stb_o, 1'b1);
                check("adr_o", bus.adr_o, a);
                if (cyc_cnt == 1) begin
                    check("dat_o", bus.dat_o, wd);
                    check("we_o", bus.we_o, ws != 4'h0);
                    check("sel_o", bus.sel_o, (ws != 4'h0) ? ws : 4'hF);
                end
                bus.mem_addr  = $urandom;
                bus.mem_wdata = $urandom;
                bus.mem_wstrb = 4'($urandom);
                if (cyc_cnt == ack_at) begin
                    if (use_err) bus.err_i = 1'b1;
                    else         bus.ack_i = 1'b1;
                    err_clr  = clr_same;
                    prev_ack = 1'b1;
                end
            end
            if (bus.mem_ready) begin
                seen  = 1'b1;
                rdy_n = n;
            end
        end
        if (set_err)                exp_err = 1'b1;
        else if (clr_same && acked) exp_err = 1'b0;
        check("ready_seen", seen, 1'b1);
        check("ready_cycle", rdy_n, exp_cyc + 1);
        check("cyc_cycles", cyc_cnt, exp_cyc);
        check("mem_rdata", bus.mem_rdata, exp_rd);
        check("bus_err", bus_err, exp_err);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        check("ready_width", bus.mem_ready, 1'b0);
        check("cyc_idle", bus.cyc_o, 1'b0);
        check("rdata_hold", bus.mem_rdata, exp_rd);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", bus_err, 1'b0);
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.dat_i     = '0;
        bus.ack_i     = 1'b0;
        bus.err_i     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cyc", bus.cyc_o, 1'b0);
        check("rst_stb", bus.stb_o, 1'b0);
        check("rst_ready", bus.mem_ready, 1'b0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_adr", bus.adr_o, 32'h0);
        check("rst_sel_we", {bus.sel_o, bus.we_o}, 5'h0);
        check("rst_err", bus_err, 1'b0);
        rst = 1'b0;

        txn(32'h100, 32'h0, 4'h0, 32'h1234_5678, 2, 1'b0, 1'b0);
        txn(32'h204, 32'hAABB_CCDD, 4'b0100, 32'h5555_5555, 2, 1'b0, 1'b0);
        txn(32'h300, 32'h0, 4'h0, 32'h0BAD_0BAD, 0, 1'b0, 1'b0);
        clear_err();
        txn(32'h400, 32'h0, 4'h0, 32'h7777_0000, 2, 1'b1, 1'b0);
        txn(32'h404, 32'h0, 4'h0, 32'h0102_0304, 1, 1'b0, 1'b0);
        txn(32'h408, 32'h0, 4'h0, 32'h0, 3, 1'b1, 1'b1);
        clear_err();
        txn(32'h500, 32'h0, 4'h0, 32'hCAFE_F00D, T, 1'b0, 1'b0);
        txn(32'h504, 32'h1111_2222, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        clear_err();

        for (int k = 0; k < 30; k++) begin
            txn($urandom, $urandom,
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                $urandom, int'($urandom_range(0, T + 2)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h600;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", bus.cyc_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", bus.cyc_o, 1'b0);
        check("async_rst_stb", bus.stb_o, 1'b0);
        check("async_rst_ready", bus.mem_ready, 1'b0);
        check("async_rst_err", bus_err, 1'b0);
        bus.mem_valid = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check("rst_no_ready", bus.mem_ready, 1'b0);
        rst = 1'b0;
        txn(32'h604, 32'h0, 4'h0, 32'h600D_D00D, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
